// File: rtl/memory_arbiter_pkg.sv
// Shared constants and types for the byte-wide memory port arbiter.
// State codes, access-size encodings, IO window defaults and the latched-request record.
package memory_arbiter_pkg;

  localparam logic [1:0] MA_IDLE  = 2'd0;
  localparam logic [1:0] MA_READ  = 2'd1;
  localparam logic [1:0] MA_WRITE = 2'd2;
  localparam logic [1:0] MA_DONE  = 2'd3;

  localparam logic [1:0] LS_SIZE_BYTE = 2'd0;
  localparam logic [1:0] LS_SIZE_HALF = 2'd1;
  localparam logic [1:0] LS_SIZE_WORD = 2'd2;
  localparam int         LS_UNSIGNED_BIT = 2;

  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;
  localparam logic [31:0] IO_END_DEF  = 32'h0004_0000;

  typedef struct packed {
    logic        is_ls;
    logic [2:0]  size;
    logic [2:0]  len;
    logic [31:0] addr;
    logic [31:0] value;
  } ma_op_t;

  function automatic logic [2:0] size_to_len(input logic [1:0] sz);
    case (sz)
      LS_SIZE_BYTE: return 3'd1;
      LS_SIZE_HALF: return 3'd2;
      default:      return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and RAM-side signals of the memory arbiter.
// master = arbiter view, slave = the surrounding fetch/LSB/RAM environment.
interface memory_arbiter_if;

  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;

  logic        ls_valid;
  logic        ls_wr;
  logic [2:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_value;
  logic        ls_ready;
  logic [31:0] ls_res;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    input  if_valid, if_addr, ls_valid, ls_wr, ls_size, ls_addr, ls_value,
    input  mem_din, io_buffer_full,
    output if_ready, if_data, ls_ready, ls_res, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output if_valid, if_addr, ls_valid, ls_wr, ls_size, ls_addr, ls_value,
    output mem_din, io_buffer_full,
    input  if_ready, if_data, ls_ready, ls_res, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/memory_arbiter_load_extend.sv
// Combinational load result formatter: picks byte/half/word from the raw little-endian
// word and sign- or zero-extends it. Also usable by store-to-load forwarding.
module mem_load_extend
  import memory_arbiter_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [2:0]  size,
  output logic [31:0] res
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
    logic signed [7:0]  b_s;
    logic signed [31:0] w_s;
    b_s = signed'(b);
    w_s = 32'(b_s);
    return uns ? {24'd0, b} : unsigned'(w_s);
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    h_s = signed'(h);
    w_s = 32'(h_s);
    return uns ? {16'd0, h} : unsigned'(w_s);
  endfunction

  always_comb begin
    res = raw;
    case (size[1:0])
      LS_SIZE_BYTE: res = ext8(raw[7:0], size[LS_UNSIGNED_BIT]);
      LS_SIZE_HALF: res = ext16(raw[15:0], size[LS_UNSIGNED_BIT]);
      default:      res = raw;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter between instruction fetch and LSB for the single byte-wide RAM/IO port;
// sequences each access as byte beats and returns the assembled result with a one-cycle ready.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEF,
  parameter logic [31:0] IO_END  = IO_END_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  memory_arbiter_if.master bus
);

  logic [1:0]  state;
  ma_op_t      op;
  logic [2:0]  issue;
  logic [2:0]  cap;
  logic        issued_q;
  logic        last_ls;
  logic [31:0] asm_q;
  logic [31:0] asm_next;
  logic [31:0] ls_ext;

  logic        if_ready_q;
  logic        ls_ready_q;
  logic [31:0] if_data_q;
  logic [31:0] ls_res_q;

  logic [31:0] beat_addr;
  logic        issuing;
  logic        capture;
  logic        wr_stall;
  logic        wr_beat;
  logic        grant_ls;
  logic        grant_if;
  logic        grant_fire;
  logic        capture_fire;

  assign beat_addr = op.addr + {29'd0, issue};
  assign issuing   = (state == MA_READ) && (issue < op.len);
  assign capture   = (state == MA_READ) && issued_q;
  assign wr_stall  = (beat_addr >= IO_BASE) && (beat_addr < IO_END) && bus.io_buffer_full;
  assign wr_beat   = (state == MA_WRITE) && rdy_in && !wr_stall;

  // Contended grants go to whichever side did not win last time.
  assign grant_ls = bus.ls_valid && (!bus.if_valid || !last_ls);
  assign grant_if = bus.if_valid && (!bus.ls_valid || last_ls);

  assign grant_fire   = rdy_in && !clear_in && (state == MA_IDLE) && (grant_ls || grant_if);
  assign capture_fire = rdy_in && !clear_in && capture;

  always_comb begin
    asm_next = asm_q;
    if (capture) asm_next[{cap[1:0], 3'b000} +: 8] = bus.mem_din;
  end

  mem_load_extend u_extend (
    .raw  (asm_next),
    .size (op.size),
    .res  (ls_ext)
  );

  assign bus.mem_a    = (issuing || state == MA_WRITE) ? beat_addr : 32'd0;
  assign bus.mem_wr   = wr_beat;
  assign bus.mem_dout = (state == MA_WRITE) ? op.value[{issue[1:0], 3'b000} +: 8] : 8'd0;
  assign bus.if_ready = if_ready_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_ready = ls_ready_q;
  assign bus.ls_res   = ls_res_q;

  // Request record and byte assembly buffer
  always_ff @(posedge clk_in) begin
    if (grant_fire) begin
      op.is_ls <= grant_ls;
      op.size  <= grant_ls ? bus.ls_size : {1'b0, LS_SIZE_WORD};
      op.len   <= grant_ls ? size_to_len(bus.ls_size[1:0]) : 3'd4;
      op.addr  <= grant_ls ? bus.ls_addr : bus.if_addr;
      op.value <= bus.ls_value;
      asm_q    <= 32'd0;
    end else if (capture_fire) begin
      asm_q    <= asm_next;
    end
  end

  // Sequencer, counters and registered results
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= MA_IDLE;
      issue      <= 3'd0;
      cap        <= 3'd0;
      issued_q   <= 1'b0;
      last_ls    <= 1'b0;
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      if_data_q  <= 32'd0;
      ls_res_q   <= 32'd0;
    end else if (!rdy_in) begin
      // A pause loses the byte in flight; rewind so it is addressed again.
      if (state == MA_READ) begin
        issue    <= cap;
        issued_q <= 1'b0;
      end
    end else begin
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      case (state)
        MA_IDLE: begin
          if (grant_fire) begin
            last_ls  <= grant_ls;
            issue    <= 3'd0;
            cap      <= 3'd0;
            issued_q <= 1'b0;
            state    <= (grant_ls && bus.ls_wr) ? MA_WRITE : MA_READ;
          end
        end
        MA_READ: begin
          if (clear_in) begin
            state <= MA_IDLE;
          end else begin
            issued_q <= issuing;
            if (issuing) issue <= issue + 3'd1;
            if (capture) begin
              cap <= cap + 3'd1;
              if ((cap + 3'd1) == op.len) begin
                state <= MA_DONE;
                if (op.is_ls) begin
                  ls_ready_q <= 1'b1;
                  ls_res_q   <= ls_ext;
                end else begin
                  if_ready_q <= 1'b1;
                  if_data_q  <= asm_next;
                end
              end
            end
          end
        end
        MA_WRITE: begin
          if (wr_beat) begin
            issue <= issue + 3'd1;
            if ((issue + 3'd1) == op.len) begin
              state      <= MA_DONE;
              ls_ready_q <= 1'b1;
              ls_res_q   <= 32'd0;
            end
          end
        end
        default: state <= MA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed scoreboard bench for memory_arbiter: expected responses, write beats and read
// addresses are queued by the stimulus and checked by an independent monitor.
module tb_memory_arbiter;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear_in;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  memory_arbiter_if bus();

  memory_arbiter dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear_in (clear_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] data; } rsp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] addr; } ra_t;

  rsp_t if_q[$];
  rsp_t ls_q[$];
  wr_t  wr_q[$];
  ra_t  ra_q[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_if(input int at, input logic [31:0] d);
    if_q.push_back('{cyc: at, data: d});
  endtask
  task automatic exp_ls(input int at, input logic [31:0] d);
    ls_q.push_back('{cyc: at, data: d});
  endtask
  task automatic exp_wr(input int at, input logic [31:0] a, input logic [7:0] d);
    wr_q.push_back('{cyc: at, addr: a, data: d});
  endtask
  task automatic exp_ra(input int at, input logic [31:0] a);
    ra_q.push_back('{cyc: at, addr: a});
  endtask

  // Byte RAM: address/write sampled mid-cycle, read data registered at the edge.
  initial begin
    logic [7:0]  ram [0:4095];
    logic [11:0] a_s;
    logic        wr_s;
    logic [7:0]  d_s;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'hEF; ram[12'h101] = 8'hBE; ram[12'h102] = 8'hAD; ram[12'h103] = 8'hDE;
    ram[12'h200] = 8'h80;
    ram[12'h204] = 8'h34; ram[12'h205] = 8'hF2;
    bus.mem_din = 8'h00;
    forever begin
      @(negedge clk_in);
      a_s  = bus.mem_a[11:0];
      wr_s = bus.mem_wr;
      d_s  = bus.mem_dout;
      @(posedge clk_in);
      bus.mem_din <= ram[a_s];
      if (wr_s) ram[a_s] = d_s;
    end
  end

  // Monitor
  initial begin
    rsp_t e;
    wr_t  w;
    ra_t  r;
    forever begin
      @(negedge clk_in);
      if (bus.if_ready) begin
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_ready unexpected: got data %h at cycle %0d, expected no pulse", bus.if_data, cyc);
        end else begin
          e = if_q.pop_front();
          check32("if_ready cycle", cyc, e.cyc);
          check32("if_data", bus.if_data, e.data);
        end
      end
      if (bus.ls_ready) begin
        if (ls_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ls_ready unexpected: got res %h at cycle %0d, expected no pulse", bus.ls_res, cyc);
        end else begin
          e = ls_q.pop_front();
          check32("ls_ready cycle", cyc, e.cyc);
          check32("ls_res", bus.ls_res, e.data);
        end
      end
      if (bus.mem_wr) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_wr unexpected: got a=%h d=%h at cycle %0d, expected none", bus.mem_a, bus.mem_dout, cyc);
        end else begin
          w = wr_q.pop_front();
          check32("mem_wr cycle", cyc, w.cyc);
          check32("mem_wr addr", bus.mem_a, w.addr);
          check32("mem_wr data", {24'd0, bus.mem_dout}, {24'd0, w.data});
        end
      end
      while (ra_q.size() > 0 && ra_q[0].cyc < cyc) begin
        r = ra_q.pop_front();
        checks++; errors++;
        $display("FAIL mem_a sample missed: got none, expected %h at cycle %0d", r.addr, r.cyc);
      end
      if (ra_q.size() > 0 && ra_q[0].cyc == cyc) begin
        r = ra_q.pop_front();
        check32("mem_a", bus.mem_a, r.addr);
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic start_ls(input logic wr, input logic [2:0] size, input logic [31:0] a,
                          input logic [31:0] v);
    bus.ls_wr = wr; bus.ls_size = size; bus.ls_addr = a; bus.ls_value = v; bus.ls_valid = 1'b1;
  endtask

  task automatic start_if(input logic [31:0] a);
    bus.if_addr = a; bus.if_valid = 1'b1;
  endtask

  task automatic finish_at(input int at);
    wait_until(at);
    bus.if_valid = 1'b0;
    bus.ls_valid = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check32({tag, " if_ready"}, 32'(bus.if_ready), 32'd0);
    check32({tag, " ls_ready"}, 32'(bus.ls_ready), 32'd0);
    check32({tag, " if_data"}, bus.if_data, 32'd0);
    check32({tag, " ls_res"}, bus.ls_res, 32'd0);
    check32({tag, " mem_wr"}, 32'(bus.mem_wr), 32'd0);
    check32({tag, " mem_a"}, bus.mem_a, 32'd0);
  endtask

  initial begin
    int c;
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    bus.if_valid = 1'b0; bus.if_addr = 32'd0;
    bus.ls_valid = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = 3'd0;
    bus.ls_addr = 32'd0; bus.ls_value = 32'd0; bus.io_buffer_full = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_outputs_zero("reset");
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    // Word fetch
    c = cyc;
    for (int i = 0; i < 4; i++) exp_ra(c + 1 + i, 32'h100 + i);
    exp_if(c + 6, 32'hDEADBEEF);
    start_if(32'h100);
    finish_at(c + 6);

    // Byte / half loads, signed and unsigned
    c = cyc; exp_ra(c + 1, 32'h200); exp_ls(c + 3, 32'hFFFFFF80);
    start_ls(1'b0, 3'b000, 32'h200, 32'd0); finish_at(c + 3);
    c = cyc; exp_ls(c + 3, 32'h00000080);
    start_ls(1'b0, 3'b100, 32'h200, 32'd0); finish_at(c + 3);
    c = cyc; exp_ls(c + 4, 32'hFFFFF234);
    start_ls(1'b0, 3'b001, 32'h204, 32'd0); finish_at(c + 4);
    c = cyc; exp_ls(c + 4, 32'h0000F234);
    start_ls(1'b0, 3'b101, 32'h204, 32'd0); finish_at(c + 4);

    // Half store into the IO window with the sink full for three cycles
    c = cyc;
    exp_wr(c + 4, 32'h00030000, 8'h34);
    exp_wr(c + 5, 32'h00030001, 8'h12);
    exp_ls(c + 6, 32'd0);
    bus.io_buffer_full = 1'b1;
    start_ls(1'b1, 3'b001, 32'h00030000, 32'h00001234);
    wait_until(c + 4);
    bus.io_buffer_full = 1'b0;
    finish_at(c + 6);

    // Fresh reset, then both requesters held high: LSB, IF, LSB, IF
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    c = cyc;
    exp_ra(c + 1, 32'h200);
    exp_ls(c + 3, 32'hFFFFFF80);
    for (int i = 0; i < 4; i++) exp_ra(c + 5 + i, 32'h100 + i);
    exp_if(c + 10, 32'hDEADBEEF);
    exp_ra(c + 12, 32'h200);
    exp_ls(c + 14, 32'hFFFFFF80);
    for (int i = 0; i < 4; i++) exp_ra(c + 16 + i, 32'h100 + i);
    exp_if(c + 21, 32'hDEADBEEF);
    start_if(32'h100);
    start_ls(1'b0, 3'b000, 32'h200, 32'd0);
    finish_at(c + 21);

    // Clear in cycle 3 of a fetch: no pulse, port idle next cycle
    c = cyc;
    for (int i = 0; i < 3; i++) exp_ra(c + 1 + i, 32'h100 + i);
    exp_ra(c + 4, 32'd0);
    exp_ra(c + 5, 32'd0);
    start_if(32'h100);
    wait_until(c + 3);
    clear_in = 1'b1; bus.if_valid = 1'b0;
    wait_until(c + 4);
    clear_in = 1'b0;
    wait_until(c + 8);

    // Clear during a word store: all beats still written, ready still pulses
    c = cyc;
    exp_wr(c + 1, 32'h300, 8'hD4);
    exp_wr(c + 2, 32'h301, 8'hC3);
    exp_wr(c + 3, 32'h302, 8'hB2);
    exp_wr(c + 4, 32'h303, 8'hA1);
    exp_ls(c + 5, 32'd0);
    start_ls(1'b1, 3'b010, 32'h300, 32'hA1B2C3D4);
    wait_until(c + 2);
    clear_in = 1'b1;
    wait_until(c + 3);
    clear_in = 1'b0;
    finish_at(c + 5);

    c = cyc;
    for (int i = 0; i < 4; i++) exp_ra(c + 1 + i, 32'h300 + i);
    exp_ls(c + 6, 32'hA1B2C3D4);
    start_ls(1'b0, 3'b010, 32'h300, 32'd0);
    finish_at(c + 6);

    // Two-cycle pause mid word load: dropped byte re-addressed
    c = cyc;
    exp_ra(c + 1, 32'h300);
    exp_ra(c + 2, 32'h301);
    exp_ra(c + 5, 32'h301);
    exp_ra(c + 6, 32'h302);
    exp_ra(c + 7, 32'h303);
    exp_ls(c + 9, 32'hA1B2C3D4);
    start_ls(1'b0, 3'b010, 32'h300, 32'd0);
    wait_until(c + 3);
    rdy_in = 1'b0;
    wait_until(c + 5);
    rdy_in = 1'b1;
    finish_at(c + 9);

    // Reset in the middle of a store
    c = cyc;
    exp_wr(c + 1, 32'h310, 8'h88);
    start_ls(1'b1, 3'b010, 32'h310, 32'h55667788);
    wait_until(c + 2);
    #2;
    rst_in = 1'b0;
    bus.ls_valid = 1'b0;
    #1;
    check_outputs_zero("mid-write reset");
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;

    check32("pending if responses", if_q.size(), 32'd0);
    check32("pending ls responses", ls_q.size(), 32'd0);
    check32("pending write beats", wr_q.size(), 32'd0);
    check32("pending read addresses", ra_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
